branch_predictor: RTL and testbench

//  Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters for the 5-stage ARM pipeline.
//  IF_Stage looks up the current PC and gets a predicted next PC in the same cycle.
//  EXE_Stage writes back the resolved outcome of each branch.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional build macro PERF_CNT_EN adds lookup/hit/mispredict performance counters.
module branch_predictor #(
    parameter int         ENTRIES  = 16,
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookupValidIn,
    input  logic [ADDR_W-1:0] lookupPCIn,
    output logic              hitOut,
    output logic              predTakenOut,
    output logic [ADDR_W-1:0] predTargetOut,
    input  logic              updENIn,
    input  logic [ADDR_W-1:0] updPCIn,
    input  logic              updTakenIn,
    input  logic [ADDR_W-1:0] updTargetIn,
    input  logic              updMispredictIn,
    input  logic              invalidateIn,
    output logic [PERF_W-1:0] lookupCntOut,
    output logic [PERF_W-1:0] hitCntOut,
    output logic [PERF_W-1:0] mispredCntOut
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic [ENTRIES-1:0] entry_valid;
    logic [TAG_W-1:0]   entry_tag    [ENTRIES];
    logic [ADDR_W-1:0]  entry_target [ENTRIES];
    logic [1:0]         entry_cnt    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign lk_idx  = lookupPCIn[IDX_W+1:2];
    assign lk_tag  = lookupPCIn[ADDR_W-1:IDX_W+2];
    assign upd_idx = updPCIn[IDX_W+1:2];
    assign upd_tag = updPCIn[ADDR_W-1:IDX_W+2];
    assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

    // Lookup reads only registered state, so an update in flight is not bypassed.
    assign hitOut        = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
    assign predTakenOut  = hitOut && entry_cnt[lk_idx][1];
    assign predTargetOut = predTakenOut ? entry_target[lk_idx] : lookupPCIn + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_cnt[i]    <= CNT_INIT;
            end
        end else if (invalidateIn) begin
            entry_valid <= '0;
        end else if (updENIn) begin
            if (upd_hit) begin
                if (updTakenIn) begin
                    entry_target[upd_idx] <= updTargetIn;
                    if (entry_cnt[upd_idx] != 2'b11)
                        entry_cnt[upd_idx] <= entry_cnt[upd_idx] + 2'b01;
                end else if (entry_cnt[upd_idx] != 2'b00) begin
                    entry_cnt[upd_idx] <= entry_cnt[upd_idx] - 2'b01;
                end
            end else if (updTakenIn) begin
                // Taken branch that misses claims the slot, evicting whatever lived there.
                entry_valid[upd_idx]  <= 1'b1;
                entry_tag[upd_idx]    <= upd_tag;
                entry_target[upd_idx] <= updTargetIn;
                entry_cnt[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] lookup_cnt;
    logic [PERF_W-1:0] hit_cnt;
    logic [PERF_W-1:0] mispred_cnt;
    logic              unused_bits;

    // Counters survive invalidateIn; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt  <= '0;
            hit_cnt     <= '0;
            mispred_cnt <= '0;
        end else begin
            lookup_cnt  <= lookup_cnt + PERF_W'(lookupValidIn);
            hit_cnt     <= hit_cnt + PERF_W'(lookupValidIn & hitOut);
            mispred_cnt <= mispred_cnt + PERF_W'(updENIn & updMispredictIn);
        end
    end

    assign lookupCntOut  = lookup_cnt;
    assign hitCntOut     = hit_cnt;
    assign mispredCntOut = mispred_cnt;
    assign unused_bits   = ^{lookupPCIn[1:0], updPCIn[1:0]};
`else
    logic unused_bits;

    assign lookupCntOut  = '0;
    assign hitCntOut     = '0;
    assign mispredCntOut = '0;
    assign unused_bits   = ^{lookupPCIn[1:0], updPCIn[1:0], lookupValidIn, updMispredictIn};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/perf sequences and randomized traffic against a behavioural BTB model.
`timescale 1ns/1ps
module tb_branch_predictor;

    localparam int ENTRIES = 16;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookupValidIn = 1'b0;
    logic [31:0] lookupPCIn = '0;
    logic        hitOut, predTakenOut;
    logic [31:0] predTargetOut;
    logic        updENIn = 1'b0;
    logic [31:0] updPCIn = '0;
    logic        updTakenIn = 1'b0;
    logic [31:0] updTargetIn = '0;
    logic        updMispredictIn = 1'b0;
    logic        invalidateIn = 1'b0;
    logic [31:0] lookupCntOut, hitCntOut, mispredCntOut;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(32), .CNT_INIT(2'b01), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .lookupValidIn(lookupValidIn), .lookupPCIn(lookupPCIn),
        .hitOut(hitOut), .predTakenOut(predTakenOut), .predTargetOut(predTargetOut),
        .updENIn(updENIn), .updPCIn(updPCIn), .updTakenIn(updTakenIn),
        .updTargetIn(updTargetIn), .updMispredictIn(updMispredictIn),
        .invalidateIn(invalidateIn),
        .lookupCntOut(lookupCntOut), .hitCntOut(hitCntOut), .mispredCntOut(mispredCntOut)
    );

    always #5 clk = ~clk;

    // Behavioural model: one record per slot, direction kept as an integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int unsigned m_lcnt, m_hcnt, m_mcnt;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1;
        end
        m_lcnt = 0; m_hcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic h, output logic t,
                                output logic [31:0] tg);
        int s;
        s  = slot_of(pc);
        h  = m_valid[s] && (m_tag[s] == tag_of(pc));
        t  = h && (m_cnt[s] >= 2);
        tg = t ? m_tgt[s] : pc + 32'd4;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs before the rising edge, then advance the model.
    task automatic step(input logic lv, input logic [31:0] lpc, input logic ue,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic um, input logic inv);
        logic        eh, et;
        logic [31:0] etg;
        int          s;
        @(negedge clk);
        lookupValidIn = lv; lookupPCIn = lpc; updENIn = ue; updPCIn = upc;
        updTakenIn = ut; updTargetIn = utgt; updMispredictIn = um; invalidateIn = inv;
        #1;
        model_lookup(lpc, eh, et, etg);
        chk("hit", 32'(hitOut), 32'(eh));
        chk("taken", 32'(predTakenOut), 32'(et));
        chk("target", predTargetOut, etg);
        chk("lookup_cnt", lookupCntOut, m_lcnt);
        chk("hit_cnt", hitCntOut, m_hcnt);
        chk("mispred_cnt", mispredCntOut, m_mcnt);
        if (PERF) begin
            if (lv) m_lcnt++;
            if (lv && eh) m_hcnt++;
            if (ue && um) m_mcnt++;
        end
        s = slot_of(upc);
        if (inv) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        end else if (ue) begin
            if (m_valid[s] && m_tag[s] == tag_of(upc)) begin
                if (ut) begin
                    m_tgt[s] = utgt;
                    m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                end else begin
                    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[s] = 1; m_tag[s] = tag_of(upc); m_tgt[s] = utgt; m_cnt[s] = 2;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        lookupValidIn = 1'b1; lookupPCIn = 32'h100; updENIn = 1'b0; invalidateIn = 1'b0;
        #1;
        chk("rst_hit", 32'(hitOut), 32'd0);
        chk("rst_taken", 32'(predTakenOut), 32'd0);
        chk("rst_target", predTargetOut, 32'h104);
        chk("rst_lookup_cnt", lookupCntOut, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] lpc;
        logic        ue;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        inv;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        model_reset();
        //          lookup        upd en/pc/taken/target            inv  hit tk  target
        tbl.push_back('{32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h104});
        tbl.push_back('{32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h104});
        tbl.push_back('{32'h100, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h200});
        tbl.push_back('{32'h100, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 32'h104});
        tbl.push_back('{32'h100, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 32'h104});
        tbl.push_back('{32'h100, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h104});
        tbl.push_back('{32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h104});
        tbl.push_back('{32'h140, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h300});
        tbl.push_back('{32'h140, 1'b1, 32'h180, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 32'h300});
        tbl.push_back('{32'h140, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h144});
        tbl.push_back('{32'h180, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h184});
        tbl.push_back('{32'hFFFFFFFC, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000});
        tbl.push_back('{32'h240, 1'b1, 32'h240, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h244});
        tbl.push_back('{32'h240, 1'b1, 32'h240, 1'b1, 32'h504, 1'b0, 1'b1, 1'b1, 32'h500});
        tbl.push_back('{32'h240, 1'b1, 32'h240, 1'b1, 32'h508, 1'b0, 1'b1, 1'b1, 32'h504});
        tbl.push_back('{32'h240, 1'b1, 32'h240, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h508});
        tbl.push_back('{32'h240, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h508});
        tbl.push_back('{32'h242, 1'b1, 32'h240, 1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h508});
        tbl.push_back('{32'h240, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 32'h244});
        tbl.push_back('{32'h344, 1'b1, 32'h344, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h348});
        tbl.push_back('{32'h344, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h348});

        repeat (2) @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].lpc, tbl[i].ue, tbl[i].upc, tbl[i].ut, tbl[i].utgt, 1'b0, tbl[i].inv);
            chk($sformatf("vec%0d_hit", i), 32'(hitOut), 32'(tbl[i].e_hit));
            chk($sformatf("vec%0d_taken", i), 32'(predTakenOut), 32'(tbl[i].e_taken));
            chk($sformatf("vec%0d_target", i), predTargetOut, tbl[i].e_tgt);
        end

        // Reset asserted while an allocating update is on the inputs: update must be lost.
        @(negedge clk);
        rst = 1'b1; updENIn = 1'b1; updPCIn = 32'h400; updTakenIn = 1'b1; updTargetIn = 32'h800;
        @(negedge clk);
        rst = 1'b0; updENIn = 1'b0;
        model_reset();
        step(1'b0, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_mid_upd_hit", 32'(hitOut), 32'd0);
        step(1'b0, 32'h240, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_cleared_hit", 32'(hitOut), 32'd0);

        // Performance sequence: 5 valid lookups with 2 hits and a single mispredict.
        do_reset();
        step(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
        step(1'b1, 32'h500, 1'b1, 32'h900, 1'b0, 32'h0,   1'b1, 1'b0);
        step(1'b1, 32'h600, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0);
        step(1'b1, 32'h700, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1);
        step(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0);
        chk("perf_lookup", lookupCntOut, PERF ? 32'd5 : 32'd0);
        chk("perf_hit", hitCntOut, PERF ? 32'd2 : 32'd0);
        chk("perf_mispred", mispredCntOut, PERF ? 32'd1 : 32'd0);
        chk("inv_keeps_miss", 32'(hitOut), 32'd0);
        do_reset();
        chk("perf_lookup_rst", lookupCntOut, 32'd0);
        chk("perf_hit_rst", hitCntOut, 32'd0);
        chk("perf_mispred_rst", mispredCntOut, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 2) != 0, rand_pc(),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
